// File: rtl/sr595_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : sr595_rx_if
//  Description : Bundle of the 74HC595-style serial link pins and the
//                decoded frame outputs of sr595_rx.
//                master : the transmitter / consumer side.
//                slave  : the receiver (sr595_rx).
//  Signals     : sclk_in, sdata_in, slatch_in  serial shift clock/data/latch
//                frame[WIDTH-1:0]              last committed frame
//                frame_valid, frame_err        commit pulse / wrong bit count
//                digit[3:0], digit_ok          hex decode of frame[6:0]
//                frame_cnt[7:0]                committed frame counter
//  Revision    : 1.0  initial release
// ============================================================================
interface sr595_rx_if #(
  parameter int WIDTH = 16
);
  logic             sclk_in;
  logic             sdata_in;
  logic             slatch_in;
  logic [WIDTH-1:0] frame;
  logic             frame_valid;
  logic             frame_err;
  logic [3:0]       digit;
  logic             digit_ok;
  logic [7:0]       frame_cnt;

  modport master (
    output sclk_in, sdata_in, slatch_in,
    input  frame, frame_valid, frame_err, digit, digit_ok, frame_cnt
  );

  modport slave (
    input  sclk_in, sdata_in, slatch_in,
    output frame, frame_valid, frame_err, digit, digit_ok, frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sr595_rx.sv
`default_nettype none
// ============================================================================
//  Module      : sr595_rx
//  Description : Receiver for a 74HC595-style serial seven-segment link.
//                Serial pins are synchronized into GCLK, shifted into a
//                WIDTH-bit register on sclk rising edges and committed to
//                'frame' on slatch rising edges. The low byte of the frame
//                is decoded as a seven-segment hex digit.
//  Ports       : GCLK  system clock
//                RSTN  asynchronous active-low reset
//                bus   sr595_rx_if.slave (serial inputs, frame outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module sr595_rx #(
  parameter int WIDTH       = 16,
  parameter int MSB_FIRST   = 1,
  parameter int SEG_ACT_LOW = 0
) (
  input  wire logic   GCLK,
  input  wire logic   RSTN,
  sr595_rx_if.slave   bus
);

  localparam int             CW        = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]  CNT_FULL  = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_SAT   = CW'(WIDTH + 1);

  // Pin vectors are ordered {sclk, sdata, slatch}.
  localparam int SCLK_B  = 2;
  localparam int SDATA_B = 1;
  localparam int SLTCH_B = 0;

  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       hist_q,  hist_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] frame_q, frame_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [3:0]       digit_q, digit_d;
  logic             digit_ok_q, digit_ok_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  logic [2:0]       rise;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] shift_nx;
  logic [CW-1:0]    bit_cnt_nx;
  logic [6:0]       seg_in;
  logic [4:0]       seg_dec;
  logic             unused_sdata_rise;

  // Returns {ok, digit}; unknown patterns decode to {0, 0}.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h3F:   seg_decode = {1'b1, 4'h0};
      7'h06:   seg_decode = {1'b1, 4'h1};
      7'h5B:   seg_decode = {1'b1, 4'h2};
      7'h4F:   seg_decode = {1'b1, 4'h3};
      7'h66:   seg_decode = {1'b1, 4'h4};
      7'h6D:   seg_decode = {1'b1, 4'h5};
      7'h7D:   seg_decode = {1'b1, 4'h6};
      7'h07:   seg_decode = {1'b1, 4'h7};
      7'h7F:   seg_decode = {1'b1, 4'h8};
      7'h6F:   seg_decode = {1'b1, 4'h9};
      7'h77:   seg_decode = {1'b1, 4'hA};
      7'h7C:   seg_decode = {1'b1, 4'hB};
      7'h39:   seg_decode = {1'b1, 4'hC};
      7'h5E:   seg_decode = {1'b1, 4'hD};
      7'h79:   seg_decode = {1'b1, 4'hE};
      7'h71:   seg_decode = {1'b1, 4'hF};
      default: seg_decode = 5'd0;
    endcase
  endfunction

  // Edge detect on the second synchronizer stage against its history flop.
  assign rise = sync2_q & ~hist_q;
  // Data is level-sampled, its edge is of no interest.
  assign unused_sdata_rise = rise[SDATA_B];

  // Data comes from the same stage as the clock so both stay aligned.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shifted = {shift_q[WIDTH-2:0], sync2_q[SDATA_B]};
    end else begin : g_lsb_first
      assign shifted = {sync2_q[SDATA_B], shift_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    sync1_d = {bus.sclk_in, bus.sdata_in, bus.slatch_in};
    sync2_d = sync1_q;
    hist_d  = sync2_q;

    // Shift is resolved first so a coincident latch commits the new bit.
    shift_nx   = shift_q;
    bit_cnt_nx = bit_cnt_q;
    if (rise[SCLK_B]) begin
      shift_nx   = shifted;
      bit_cnt_nx = (bit_cnt_q == CNT_SAT) ? bit_cnt_q : bit_cnt_q + 1'b1;
    end

    seg_in  = (SEG_ACT_LOW != 0) ? ~shift_nx[6:0] : shift_nx[6:0];
    seg_dec = seg_decode(seg_in);

    // The shift register is never cleared by a commit, as on a real 595.
    shift_d       = shift_nx;
    bit_cnt_d     = bit_cnt_nx;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    digit_d       = digit_q;
    digit_ok_d    = digit_ok_q;
    frame_cnt_d   = frame_cnt_q;

    if (rise[SLTCH_B]) begin
      frame_d       = shift_nx;
      frame_valid_d = 1'b1;
      frame_err_d   = (bit_cnt_nx != CNT_FULL);
      frame_cnt_d   = frame_cnt_q + 8'd1;
      bit_cnt_d     = '0;
      digit_d       = seg_dec[3:0];
      digit_ok_d    = seg_dec[4];
    end
  end

  always_ff @(posedge GCLK or negedge RSTN) begin
    if (!RSTN) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      hist_q        <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      digit_q       <= 4'd0;
      digit_ok_q    <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      hist_q        <= hist_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      digit_q       <= digit_d;
      digit_ok_q    <= digit_ok_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign bus.frame       = frame_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.digit       = digit_q;
  assign bus.digit_ok    = digit_ok_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire
